// File: rtl/booth_r4_seq_mul.sv
// booth_r4_seq_mul: sequential radix-4 Booth signed 32x32 -> 64 multiplier.
// The 66-bit accumulator holds a 34-bit partial product above the scanned operand.
// Each iteration adds 0, +-A or +-2A into the upper part, then shifts the whole accumulator right by 2.
// The result output shows the accumulator's low 64 bits. They are zero in IDLE and form the product in DONE.

module booth_r4_seq_mul (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_start,
   input  logic        op_clear,
   input  logic [31:0] multiplier,
   input  logic [31:0] multiplicand,
   output logic [63:0] result,
   output logic        op_busy,
   output logic        op_done
);

   localparam int unsigned OP_W      = 32;
   localparam int unsigned HI_W      = OP_W + 2;
   localparam int unsigned ACC_W     = HI_W + OP_W;
   localparam int unsigned PROD_W    = 2 * OP_W;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned LAST_ITER = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [OP_W-1:0]    a_reg;
   logic               x_before;
   logic [CNT_W-1:0]   count;

   logic [HI_W-1:0]    a_ext_c;
   logic [HI_W-1:0]    booth_sel_c;
   logic [HI_W-1:0]    hi_sum_c;
   logic [ACC_W-1:0]   acc_shift_c;

   // Booth digit selection from {b1, b0, x_before}, partial-sum add and arithmetic shift
   always_comb begin
      a_ext_c     = {{2{a_reg[OP_W-1]}}, a_reg};
      booth_sel_c = '0;
      case ({acc[1], acc[0], x_before})
         3'b001, 3'b010: booth_sel_c = a_ext_c;
         3'b011:         booth_sel_c = {a_ext_c[HI_W-2:0], 1'b0};
         3'b100:         booth_sel_c = HI_W'(-{a_ext_c[HI_W-2:0], 1'b0});
         3'b101, 3'b110: booth_sel_c = HI_W'(-a_ext_c);
         default:        booth_sel_c = '0;
      endcase
      hi_sum_c    = HI_W'(acc[ACC_W-1:OP_W] + booth_sel_c);
      acc_shift_c = {{2{acc[ACC_W-1]}}, acc[ACC_W-1:2]};
   end

   // Control FSM plus datapath registers. op_clear has priority over everything except reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         acc      <= '0;
         a_reg    <= '0;
         x_before <= 1'b0;
         count    <= '0;
         op_busy  <= 1'b0;
         op_done  <= 1'b0;
      end else if (op_clear) begin
         state    <= IDLE;
         acc      <= '0;
         x_before <= 1'b0;
         count    <= '0;
         op_busy  <= 1'b0;
         op_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (op_start) begin
                  a_reg    <= multiplier;
                  acc      <= {HI_W'(0), multiplicand};
                  x_before <= 1'b0;
                  count    <= '0;
                  op_busy  <= 1'b1;
                  state    <= ADD;
               end
            end
            ADD: begin
               acc[ACC_W-1:OP_W] <= hi_sum_c;
               state             <= SHIFT;
            end
            SHIFT: begin
               acc      <= acc_shift_c;
               x_before <= acc[1];
               count    <= count + CNT_W'(1);
               if (count == CNT_W'(LAST_ITER)) begin
                  op_busy <= 1'b0;
                  op_done <= 1'b1;
                  state   <= DONE;
               end else begin
                  state   <= ADD;
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Result taps the registered accumulator. It is zero whenever the FSM is in IDLE.
   assign result = acc[PROD_W-1:0];

endmodule

// File: doc/booth_r4_seq_mul.md
# booth_r4_seq_mul

Sequential radix-4 Booth signed multiplier core for the ALU's multiply path. It latches two signed 32-bit operands and runs 16 add/shift iterations. Each iteration encodes the low two bits of the scanned operand plus the remembered previous bit, adds 0, ±A or ±2A into the upper accumulator, then arithmetic-shifts the accumulator and scanned operand right by 2. It presents the exact 64-bit signed product with a start/done handshake to the ALU result mux.

## Interface

Parameters:
- none (widths fixed: 32-bit operands, 64-bit product, 16 iterations)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces all state and outputs to reset values immediately
- op_start  input  1  start request; sampled only in IDLE
- op_clear  input  1  synchronous clear/abort; returns to IDLE from any state
- multiplier  input  32  signed operand A, the value that is added or subtracted
- multiplicand  input  32  signed operand B, the scanned operand; latched with A
- result  output  64  signed product; valid while op_done=1
- op_busy  output  1  high in ADD and SHIFT
- op_done  output  1  high in DONE

## Operation

State machine has four states: IDLE, ADD, SHIFT, DONE. The encoding is free.
- IDLE, op_clear=1: stay in IDLE; result is 0.
- IDLE, op_start=1, op_clear=0: latch A and B, clear the accumulator, set x_before=0 and count=0, go to ADD.
- ADD: Booth-encode {B[1], B[0], x_before} and add the selection into the upper accumulator. Go to SHIFT.
- SHIFT:
  - set x_before=B[1]
  - arithmetic-shift the accumulator right by 2 and B right by 2
  - increment count
  - if count was 15, go to DONE; otherwise go to ADD
- DONE: hold result. op_start is ignored. op_clear returns to IDLE and zeroes result.
- op_clear in ADD or SHIFT aborts to IDLE; result is zeroed and no done pulse is produced.
- op_start in ADD, SHIFT or DONE is ignored; latched operands do not change.
- op_clear and op_start together: op_clear wins.

Booth encoding of {b1, b0, x_before}:
- 000 and 111 add 0
- 001 and 010 add +A
- 011 adds +2A
- 100 adds −2A
- 101 and 110 add −A

Arithmetic and width rules:
- Keep the accumulator as 66 bits signed: a 34-bit upper part and a 32-bit lower part.
- Sign-extend A to 34 bits before forming ±A or ±2A. Subtraction uses two's complement. The 34-bit add is modulo 2^34, so ±2A never overflows.
- The shift is arithmetic: the top 2 bits are copies of the sign bit.
- result is accumulator bits [63:0] after the 16th shift. It is the exact product for every operand pair, including −2^31 × −2^31.
- result is driven 0 in IDLE. In ADD and SHIFT it reflects the intermediate accumulator bits [63:0]; these values are not valid.

## Timing

Reset values (asynchronous, immediate):
- state IDLE
- result = 0
- op_busy = 0
- op_done = 0
- count = 0
- x_before = 0

Latency:
- Edge E0: op_start is sampled in IDLE; op_busy goes high after E0.
- Edges E1 to E32: 16 ADD/SHIFT pairs, alternating ADD, SHIFT.
- After E32: op_done=1 and op_busy=0. Total latency is 32 cycles from the start edge to op_done high.
- op_done stays high until op_clear is sampled. op_done falls on the edge that samples op_clear; IDLE is entered on that same edge.

Other rules:
- Back-to-back operations need op_clear (1 cycle), then op_start. The minimum period is 34 cycles.
- reset asserted mid-operation: outputs return to reset values without waiting for a clock edge. After reset is released, the block waits in IDLE for a new op_start.
- Operand inputs are don't-care except in the op_start cycle in IDLE.

## Test plan

- Reset mid-run: start 5×6 and assert reset after 10 cycles. Required: result=0, op_busy=0 and op_done=0 immediately. A new start of 5×6 then returns 30.
- Basic and zero products:
  - A=7, B=3: op_done exactly 32 cycles after the start edge, result=0x0000000000000015.
  - A=0x12345678, B=0: result=0.
- Negatives: A=0xFFFFFFFF, B=0xFFFFFFFF (−1×−1) -> result=0x0000000000000001.
- Extremes:
  - A=B=0x80000000 -> result=0x4000000000000000.
  - A=0x7FFFFFFF, B=0x80000000 -> result=0xC000000080000000.
- Abort and ignore:
  - op_clear during the 5th ADD: IDLE next cycle, result=0, no op_done.
  - op_start pulsed at cycles 3 and 20 of a 9×−4 run: ignored, result=0xFFFFFFFFFFFFFFDC.
- Simultaneous events and hold:
  - op_start and op_clear together in IDLE: stays in IDLE.
  - op_start while in DONE: result is held unchanged until op_clear.
